tx_try_status_gen: RTL and testbench

//  Per-packet transmit-attempt tracker between the tx engine/ACK-timeout logic and tx_status_fifo.

---
 rtl/tx_try_status_gen_pkg.sv | 36 +++
 rtl/tx_try_status_gen_if.sv | 40 ++++
 rtl/tx_try_status_gen_ack_watchdog.sv | 31 +++
 rtl/tx_try_status_gen.sv | 137 +++++++++++++
 tb/tb_tx_try_status_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_try_status_gen_pkg.sv
// rtl/tx_try_status_gen_pkg.sv - shared widths, state encoding and status helpers for the tx try tracker
package tx_try_status_gen_pkg;

  localparam int PRIO_W           = 2;
  localparam int QIDX_W           = 2;
  localparam int SN_W             = 10;
  localparam int STATUS_W         = 5;
  localparam int RETRY_W          = 4;
  localparam int STATUS_FAIL_BIT  = 4;
  localparam int STATUS_RETRY_MSB = 3;

  localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX       = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } tx_state_e;

  // Status word: fail flag on top, retransmissions used below it.
  function automatic logic [STATUS_W-1:0] pack_status(input logic fail,
                                                      input logic [RETRY_W-1:0] cnt);
    logic [STATUS_W-1:0] s;
    s                              = '0;
    s[STATUS_FAIL_BIT]             = fail;
    s[STATUS_RETRY_MSB:0]          = cnt;
    return s;
  endfunction

  // Retry counter never wraps past 15.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] c);
    return (c == RETRY_MAX) ? c : c + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/tx_try_status_gen_if.sv
// rtl/tx_try_status_gen_if.sv - launch/attempt/ack inputs and status outputs of the tx try tracker
interface tx_try_status_gen_if;
  import tx_try_status_gen_pkg::*;

  logic                pkt_launch;
  logic [PRIO_W-1:0]   linux_prio_in;
  logic [QIDX_W-1:0]   tx_queue_idx_in;
  logic [SN_W-1:0]     tx_pkt_sn_in;
  logic                ack_req_in;
  logic [RETRY_W-1:0]  retry_limit_in;
  logic                phy_tx_end;
  logic                ack_ok;
  logic                ack_timeout;

  logic                retrans_req;
  logic                busy;
  logic                tx_try_complete;
  logic [STATUS_W-1:0] tx_status;
  logic [PRIO_W-1:0]   linux_prio;
  logic [QIDX_W-1:0]   tx_queue_idx;
  logic [SN_W-1:0]     tx_pkt_sn;
  logic                proto_err;

  // Tx engine / ACK logic side.
  modport master (
    output pkt_launch, linux_prio_in, tx_queue_idx_in, tx_pkt_sn_in,
           ack_req_in, retry_limit_in, phy_tx_end, ack_ok, ack_timeout,
    input  retrans_req, busy, tx_try_complete, tx_status,
           linux_prio, tx_queue_idx, tx_pkt_sn, proto_err
  );

  // Tracker side.
  modport slave (
    input  pkt_launch, linux_prio_in, tx_queue_idx_in, tx_pkt_sn_in,
           ack_req_in, retry_limit_in, phy_tx_end, ack_ok, ack_timeout,
    output retrans_req, busy, tx_try_complete, tx_status,
           linux_prio, tx_queue_idx, tx_pkt_sn, proto_err
  );

endinterface

// File: rtl/tx_try_status_gen_ack_watchdog.sv
// rtl/tx_try_status_gen_ack_watchdog.sv - backstop counter that forces an ACK timeout
module tx_try_status_gen_ack_watchdog #(
  parameter int ACK_WAIT_MAX = 1024,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  import tx_try_status_gen_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count waiting cycles; hold at the last value so expire stays asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/tx_try_status_gen.sv
// rtl/tx_try_status_gen.sv - per-packet transmit attempt tracker feeding the tx status fifo
module tx_try_status_gen #(
  parameter int ACK_WAIT_MAX = 1024,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  tx_try_status_gen_if.slave tx
);
  import tx_try_status_gen_pkg::*;

  tx_state_e           state_q;
  logic                ack_req_q;
  logic [RETRY_W-1:0]  retry_limit_q;
  logic [RETRY_W-1:0]  retry_cnt_q;
  logic [RETRY_W-1:0]  retry_cnt_d;
  logic                retrans_q;
  logic                busy_q;
  logic                complete_q;
  logic [STATUS_W-1:0] status_q;
  logic [PRIO_W-1:0]   prio_q;
  logic [QIDX_W-1:0]   qidx_q;
  logic [SN_W-1:0]     sn_q;
  logic                proto_err_q;

  logic wd_clr;
  logic wd_en;
  logic wd_expire;
  logic timeout_evt;
  logic launch_err;
  logic phy_err;

  // The watchdog restarts each time an attempt ends and the ACK wait begins.
  assign wd_clr      = (state_q == ST_TX) && tx.phy_tx_end && ack_req_q;
  assign wd_en       = (state_q == ST_WAIT_ACK);
  assign timeout_evt = tx.ack_timeout || wd_expire;
  assign retry_cnt_d = sat_inc(retry_cnt_q);

  // Launch is only legal from IDLE (DONE included as illegal); attempt end only in TX.
  assign launch_err  = tx.pkt_launch && (state_q != ST_IDLE);
  assign phy_err     = tx.phy_tx_end && (state_q != ST_TX);

  tx_try_status_gen_ack_watchdog #(
    .ACK_WAIT_MAX (ACK_WAIT_MAX),
    .CNT_W        (CNT_W)
  ) u_ack_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Packet FSM with registered pulses, status and latched metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ack_req_q     <= 1'b0;
      retry_limit_q <= '0;
      retry_cnt_q   <= '0;
      retrans_q     <= 1'b0;
      busy_q        <= 1'b0;
      complete_q    <= 1'b0;
      status_q      <= '0;
      prio_q        <= '0;
      qidx_q        <= '0;
      sn_q          <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      retrans_q  <= 1'b0;
      complete_q <= 1'b0;
      if (launch_err || phy_err) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (tx.pkt_launch) begin
            prio_q        <= tx.linux_prio_in;
            qidx_q        <= tx.tx_queue_idx_in;
            sn_q          <= tx.tx_pkt_sn_in;
            ack_req_q     <= tx.ack_req_in;
            retry_limit_q <= tx.retry_limit_in;
            retry_cnt_q   <= '0;
            busy_q        <= 1'b1;
            state_q       <= ST_TX;
          end
        end
        ST_TX: begin
          if (tx.phy_tx_end) begin
            if (ack_req_q) begin
              state_q <= ST_WAIT_ACK;
            end else begin
              state_q    <= ST_DONE;
              complete_q <= 1'b1;
              status_q   <= pack_status(1'b0, retry_cnt_q);
            end
          end
        end
        ST_WAIT_ACK: begin
          if (tx.ack_ok) begin
            state_q    <= ST_DONE;
            complete_q <= 1'b1;
            status_q   <= pack_status(1'b0, retry_cnt_q);
          end else if (timeout_evt) begin
            if (retry_cnt_q == retry_limit_q) begin
              state_q    <= ST_DONE;
              complete_q <= 1'b1;
              status_q   <= pack_status(1'b1, retry_cnt_q);
            end else begin
              retry_cnt_q <= retry_cnt_d;
              retrans_q   <= 1'b1;
              state_q     <= ST_TX;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx.retrans_req     = retrans_q;
  assign tx.busy            = busy_q;
  assign tx.tx_try_complete = complete_q;
  assign tx.tx_status       = status_q;
  assign tx.linux_prio      = prio_q;
  assign tx.tx_queue_idx    = qidx_q;
  assign tx.tx_pkt_sn       = sn_q;
  assign tx.proto_err       = proto_err_q;

endmodule

// File: tb/tb_tx_try_status_gen.sv
// tb/tb_tx_try_status_gen.sv - directed vector bench for the tx try tracker
module tb_tx_try_status_gen;

  logic clk;
  logic rst;

  tx_try_status_gen_if bus ();

  tx_try_status_gen #(
    .ACK_WAIT_MAX (16),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic [1:0] prio;
    logic [1:0] q;
    logic [9:0] sn;
    logic       areq;
    logic [3:0] lim;
    logic       pe;
    logic       ok;
    logic       to;
    logic       e_retr;
    logic       e_busy;
    logic       e_cmpl;
    logic [4:0] e_st;
    logic [9:0] e_sn;
    logic [1:0] e_prio;
    logic [1:0] e_q;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [1:0] cur_prio;
  logic [1:0] cur_q;
  logic [9:0] cur_sn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pkt_launch      = 1'b0;
    bus.linux_prio_in   = 2'd0;
    bus.tx_queue_idx_in = 2'd0;
    bus.tx_pkt_sn_in    = 10'd0;
    bus.ack_req_in      = 1'b0;
    bus.retry_limit_in  = 4'd0;
    bus.phy_tx_end      = 1'b0;
    bus.ack_ok          = 1'b0;
    bus.ack_timeout     = 1'b0;
  endtask

  task automatic add_launch(input logic [1:0] p, input logic [1:0] q, input logic [9:0] sn,
                            input logic areq, input logic [3:0] lim);
    vec_t v;
    cur_prio = p; cur_q = q; cur_sn = sn;
    v = '{l:1'b1, prio:p, q:q, sn:sn, areq:areq, lim:lim, pe:1'b0, ok:1'b0, to:1'b0,
          e_retr:1'b0, e_busy:1'b1, e_cmpl:1'b0, e_st:5'h00, e_sn:sn, e_prio:p, e_q:q};
    tbl.push_back(v);
  endtask

  // Non-launch cycle: metadata inputs carry junk that must not be latched.
  task automatic add_row(input logic pe, input logic ok, input logic to,
                         input logic er, input logic eb, input logic ec, input logic [4:0] est);
    vec_t v;
    v = '{l:1'b0, prio:~cur_prio, q:~cur_q, sn:~cur_sn, areq:1'b1, lim:4'hF,
          pe:pe, ok:ok, to:to, e_retr:er, e_busy:eb, e_cmpl:ec, e_st:est,
          e_sn:cur_sn, e_prio:cur_prio, e_q:cur_q};
    tbl.push_back(v);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".busy"},     32'(bus.busy), 32'd0);
    chk({tag, ".complete"}, 32'(bus.tx_try_complete), 32'd0);
    chk({tag, ".retrans"},  32'(bus.retrans_req), 32'd0);
    chk({tag, ".status"},   32'(bus.tx_status), 32'd0);
    chk({tag, ".sn"},       32'(bus.tx_pkt_sn), 32'd0);
    chk({tag, ".prio"},     32'(bus.linux_prio), 32'd0);
    chk({tag, ".qidx"},     32'(bus.tx_queue_idx), 32'd0);
    chk({tag, ".proto"},    32'(bus.proto_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  wa_cycles;
    logic saw_retr;
    logic saw_cmpl;

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // 1: no-ack packet, attempt ends 5 cycles after launch.
    add_launch(2'd2, 2'd1, 10'h155, 1'b0, 4'd0);
    repeat (4) add_row(0, 0, 0, 0, 1, 0, 5'h00);
    add_row(1, 0, 0, 0, 1, 1, 5'h00);
    add_row(0, 0, 0, 0, 0, 0, 5'h00);
    // 2: two ACK timeouts then ACK, limit 3.
    add_launch(2'd1, 2'd3, 10'h0A1, 1'b1, 4'd3);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 0, 1, 1, 1, 0, 5'h00);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 0, 1, 1, 1, 0, 5'h00);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 1, 0, 0, 1, 1, 5'h02);
    add_row(0, 0, 0, 0, 0, 0, 5'h00);
    // 3: three timeouts with limit 2 -> failure after two retries.
    add_launch(2'd3, 2'd0, 10'h3FF, 1'b1, 4'd2);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 0, 1, 1, 1, 0, 5'h00);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 0, 1, 1, 1, 0, 5'h00);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 0, 1, 0, 1, 1, 5'h12);
    add_row(0, 0, 0, 0, 0, 0, 5'h00);
    // 5: ack events in TX ignored; simultaneous ack_ok and ack_timeout -> success.
    add_launch(2'd0, 2'd2, 10'h001, 1'b1, 4'd5);
    add_row(0, 1, 1, 0, 1, 0, 5'h00);
    add_row(1, 0, 0, 0, 1, 0, 5'h00);
    add_row(0, 1, 1, 0, 1, 1, 5'h00);
    add_row(0, 0, 0, 0, 0, 0, 5'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.pkt_launch      = tbl[i].l;
      bus.linux_prio_in   = tbl[i].prio;
      bus.tx_queue_idx_in = tbl[i].q;
      bus.tx_pkt_sn_in    = tbl[i].sn;
      bus.ack_req_in      = tbl[i].areq;
      bus.retry_limit_in  = tbl[i].lim;
      bus.phy_tx_end      = tbl[i].pe;
      bus.ack_ok          = tbl[i].ok;
      bus.ack_timeout     = tbl[i].to;
      tick();
      chk($sformatf("v%0d.retrans", i),  32'(bus.retrans_req),     32'(tbl[i].e_retr));
      chk($sformatf("v%0d.busy", i),     32'(bus.busy),            32'(tbl[i].e_busy));
      chk($sformatf("v%0d.complete", i), 32'(bus.tx_try_complete), 32'(tbl[i].e_cmpl));
      chk($sformatf("v%0d.sn", i),       32'(bus.tx_pkt_sn),       32'(tbl[i].e_sn));
      chk($sformatf("v%0d.prio", i),     32'(bus.linux_prio),      32'(tbl[i].e_prio));
      chk($sformatf("v%0d.qidx", i),     32'(bus.tx_queue_idx),    32'(tbl[i].e_q));
      chk($sformatf("v%0d.proto", i),    32'(bus.proto_err),       32'd0);
      if (tbl[i].e_cmpl) begin
        chk($sformatf("v%0d.status", i), 32'(bus.tx_status),       32'(tbl[i].e_st));
      end
    end
    idle_inputs();

    // 4: watchdog forced timeout, limit 0 -> immediate failure.
    bus.pkt_launch     = 1'b1;
    bus.tx_pkt_sn_in   = 10'h2AA;
    bus.ack_req_in     = 1'b1;
    bus.retry_limit_in = 4'd0;
    tick();
    idle_inputs();
    bus.phy_tx_end = 1'b1;
    tick();
    idle_inputs();
    wa_cycles = 0;
    saw_retr  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.retrans_req) saw_retr = 1'b1;
      if (bus.tx_try_complete) begin
        wa_cycles = k;
        break;
      end
    end
    chk("wd.cycles", 32'(wa_cycles), 32'd16);
    chk("wd.status", 32'(bus.tx_status), 32'h10);
    chk("wd.retrans_seen", 32'(saw_retr), 32'd0);
    chk("wd.sn", 32'(bus.tx_pkt_sn), 32'h2AA);
    tick();
    chk("wd.busy_after", 32'(bus.busy), 32'd0);
    chk("wd.complete_after", 32'(bus.tx_try_complete), 32'd0);

    // 6: launch while in TX is ignored and flags proto_err; reset aborts in WAIT_ACK.
    bus.pkt_launch      = 1'b1;
    bus.linux_prio_in   = 2'd1;
    bus.tx_queue_idx_in = 2'd1;
    bus.tx_pkt_sn_in    = 10'h111;
    bus.ack_req_in      = 1'b1;
    bus.retry_limit_in  = 4'd1;
    tick();
    chk("p6.proto_before", 32'(bus.proto_err), 32'd0);
    bus.linux_prio_in   = 2'd3;
    bus.tx_queue_idx_in = 2'd2;
    bus.tx_pkt_sn_in    = 10'h222;
    tick();
    idle_inputs();
    chk("p6.proto_after", 32'(bus.proto_err), 32'd1);
    chk("p6.sn_kept", 32'(bus.tx_pkt_sn), 32'h111);
    chk("p6.prio_kept", 32'(bus.linux_prio), 32'd1);
    chk("p6.qidx_kept", 32'(bus.tx_queue_idx), 32'd1);
    chk("p6.busy", 32'(bus.busy), 32'd1);
    bus.phy_tx_end = 1'b1;
    tick();
    idle_inputs();
    chk("p6.in_wait_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    saw_cmpl = 1'b0;
    repeat (2) begin
      tick();
      if (bus.tx_try_complete) saw_cmpl = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      if (bus.tx_try_complete) saw_cmpl = 1'b1;
    end
    chk("rst.no_complete", 32'(saw_cmpl), 32'd0);
    chk("rst.busy_idle", 32'(bus.busy), 32'd0);
    chk("rst.proto_cleared", 32'(bus.proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
